bomb_controller: RTL

BOMB_CONTROLLER -- requirements
Module: bomb_controller

---
 rtl/bomb_controller.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/bomb_controller.sv
// rtl/bomb_controller.sv - single-bomb placement, fuse, blast cross, hit detect and pixel overlay
// Optional feature: define BOMB_REMOTE_DETONATE_EN so a second place press while armed detonates at once.
module bomb_controller #(
  parameter int FUSE_CYCLES  = 200_000_000,
  parameter int BLAST_CYCLES = 50_000_000,
  parameter int BLAST_RANGE  = 2,
  parameter int TILE_SHIFT   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        C,
  input  logic [9:0]  b_x,
  input  logic [9:0]  b_y,
  input  logic        game_over,
  input  logic [9:0]  v_x,
  input  logic [9:0]  v_y,
  output logic        bomb_active,
  output logic        exploding,
  output logic [5:0]  bomb_tx,
  output logic [5:0]  bomb_ty,
  output logic        bomberman_hit,
  output logic [11:0] rgb_out,
  output logic        rgb_en
);

  localparam int MAX_CYC  = (FUSE_CYCLES > BLAST_CYCLES) ? FUSE_CYCLES : BLAST_CYCLES;
  localparam int CW       = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);
  localparam logic [CW-1:0] FUSE_LOAD  = CW'(FUSE_CYCLES - 1);
  localparam logic [CW-1:0] BLAST_LOAD = CW'(BLAST_CYCLES - 1);
  localparam logic [10:0] HALF_TILE    = 11'(1 << (TILE_SHIFT - 1));
  localparam logic [12:0] RANGE_W      = 13'(BLAST_RANGE);

`ifdef BOMB_REMOTE_DETONATE_EN
  localparam bit REMOTE_DET = 1'b1;
`else
  localparam bit REMOTE_DET = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    EXPLODE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          c_q;
  logic          c_rdy_q;
  logic [5:0]    bomb_tx_q, bomb_tx_d;
  logic [5:0]    bomb_ty_q, bomb_ty_d;
  logic          hit_q, hit_d;
  logic [11:0]   rgb_q, rgb_d;
  logic          rgb_en_q, rgb_en_d;

  logic          place_req;
  logic [10:0]   bm_tx, bm_ty;
  logic [10:0]   pix_tx, pix_ty;

  // Bomberman tile uses centre rounding; pixel tile is plain truncation.
  function automatic logic [10:0] round_tile(input logic [9:0] p);
    round_tile = ({1'b0, p} + HALF_TILE) >> TILE_SHIFT;
  endfunction

  // Signed distance test so tiles near 0 never alias with tiles near the far edge.
  function automatic logic in_cross(input logic [10:0] tx, input logic [10:0] ty,
                                    input logic [5:0] btx, input logic [5:0] bty);
    logic signed [12:0] dx, dy;
    logic [12:0]        adx, ady;
    dx  = $signed({2'b00, tx}) - $signed({7'b0, btx});
    dy  = $signed({2'b00, ty}) - $signed({7'b0, bty});
    adx = dx[12] ? $unsigned(-dx) : $unsigned(dx);
    ady = dy[12] ? $unsigned(-dy) : $unsigned(dy);
    in_cross = ((ty == {5'b0, bty}) && (adx <= RANGE_W)) ||
               ((tx == {5'b0, btx}) && (ady <= RANGE_W));
  endfunction

  assign bm_tx  = round_tile(b_x);
  assign bm_ty  = round_tile(b_y);
  assign pix_tx = {1'b0, v_x} >> TILE_SHIFT;
  assign pix_ty = {1'b0, v_y} >> TILE_SHIFT;

  // A press counts only once C has been seen low since reset, so a held button cannot fire.
  assign place_req = C && !c_q && c_rdy_q && !game_over;

  // Next-state, fuse/blast counter, tile latch and registered display/hit outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bomb_tx_d = bomb_tx_q;
    bomb_ty_d = bomb_ty_q;
    hit_d     = hit_q;
    rgb_d     = rgb_q;
    rgb_en_d  = rgb_en_q;

    if (!game_over) begin
      case (state_q)
        IDLE: begin
          if (place_req) begin
            state_d   = ARMED;
            cnt_d     = FUSE_LOAD;
            bomb_tx_d = bm_tx[5:0];
            bomb_ty_d = bm_ty[5:0];
          end
        end
        ARMED: begin
          if (REMOTE_DET && place_req) begin
            state_d = EXPLODE;
            cnt_d   = BLAST_LOAD;
          end else if (cnt_q == '0) begin
            state_d = EXPLODE;
            cnt_d   = BLAST_LOAD;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        EXPLODE: begin
          if (cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase

      hit_d    = (state_q == EXPLODE) && in_cross(bm_tx, bm_ty, bomb_tx_q, bomb_ty_q);
      rgb_d    = 12'h000;
      rgb_en_d = 1'b0;
      if ((state_q == EXPLODE) && in_cross(pix_tx, pix_ty, bomb_tx_q, bomb_ty_q)) begin
        rgb_d    = 12'hF80;
        rgb_en_d = 1'b1;
      end else if ((state_q == ARMED) && (pix_tx == {5'b0, bomb_tx_q}) &&
                   (pix_ty == {5'b0, bomb_ty_q})) begin
        rgb_d    = 12'h333;
        rgb_en_d = 1'b1;
      end
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      c_q       <= 1'b0;
      c_rdy_q   <= 1'b0;
      bomb_tx_q <= 6'd0;
      bomb_ty_q <= 6'd0;
      hit_q     <= 1'b0;
      rgb_q     <= 12'h000;
      rgb_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      c_q       <= C;
      c_rdy_q   <= c_rdy_q || !C;
      bomb_tx_q <= bomb_tx_d;
      bomb_ty_q <= bomb_ty_d;
      hit_q     <= hit_d;
      rgb_q     <= rgb_d;
      rgb_en_q  <= rgb_en_d;
    end
  end

  assign bomb_active   = (state_q == ARMED);
  assign exploding     = (state_q == EXPLODE);
  assign bomb_tx       = bomb_tx_q;
  assign bomb_ty       = bomb_ty_q;
  assign bomberman_hit = hit_q;
  assign rgb_out       = rgb_q;
  assign rgb_en        = rgb_en_q;

endmodule
